// File: rtl/ethernet_rx_frame.sv
// ethernet_rx_frame: strips preamble/SFD, forwards payload minus FCS through a 5-byte delay line,
// checks CRC-32, length limits and rx_er, and counts good/bad frames.
module ethernet_rx_frame #(
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = 1522,
  parameter int COUNTER_WIDTH   = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               io_in_data,
  input  logic                     io_in_valid,
  input  logic                     io_in_error,
  output logic                     io_out_valid,
  output logic [7:0]               io_out_data,
  output logic                     io_out_last,
  output logic                     io_out_error,
  output logic [COUNTER_WIDTH-1:0] io_good_frames,
  output logic [COUNTER_WIDTH-1:0] io_bad_frames
);
  localparam logic [1:0] IDLE = 2'd0, PRE = 2'd1, DATA = 2'd2, DROP = 2'd3;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
  logic [1:0] state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [10:0] len_q, len_d;
  logic [2:0] cnt_q, cnt_d;
  logic [4:0][7:0] dl_q, dl_d;
  logic er_q, er_d, ov_q, ov_d, ol_q, ol_d, oe_q, oe_d;
  logic [7:0] od_q, od_d;
  logic [COUNTER_WIDTH-1:0] good_q, good_d, bad_q, bad_d;
  logic end_bad;
  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction
  assign end_bad = er_q | (crc_q != RESIDUE) | (len_q < 11'(MIN_FRAME_BYTES));
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    dl_d    = dl_q;
    er_d    = er_q;
    ov_d    = 1'b0;
    od_d    = 8'h00;
    ol_d    = 1'b0;
    oe_d    = 1'b0;
    good_d  = good_q;
    bad_d   = bad_q;
    case (state_q)
      IDLE: if (io_in_valid) state_d = (io_in_data == 8'h55) ? PRE : DROP;
      PRE: begin
        if (!io_in_valid) state_d = IDLE;
        else if (io_in_error) begin
          state_d = DROP;
          bad_d   = bad_q + COUNTER_WIDTH'(1);
        end else if (io_in_data == 8'hD5) begin
          state_d = DATA;
          crc_d   = '1;
          len_d   = '0;
          cnt_d   = '0;
          dl_d    = '0;
          er_d    = 1'b0;
        end else if (io_in_data != 8'h55) state_d = DROP;
      end
      DATA: begin
        if (!io_in_valid) begin
          state_d = IDLE;
          ov_d    = cnt_q == 3'd5;
          od_d    = ov_d ? dl_q[4] : 8'h00;
          ol_d    = ov_d;
          oe_d    = ov_d & end_bad;
          good_d  = (ov_d & !end_bad) ? good_q + COUNTER_WIDTH'(1) : good_q;
          bad_d   = (!ov_d | end_bad) ? bad_q + COUNTER_WIDTH'(1) : bad_q;
        end else if (len_q >= 11'(MAX_FRAME_BYTES)) begin
          state_d = DROP;
          ov_d    = 1'b1;
          od_d    = dl_q[4];
          ol_d    = 1'b1;
          oe_d    = 1'b1;
          bad_d   = bad_q + COUNTER_WIDTH'(1);
        end else begin
          crc_d = crc_next(crc_q, io_in_data);
          len_d = len_q + {10'd0, ~&len_q};
          er_d  = er_q | io_in_error;
          dl_d  = {dl_q[3:0], io_in_data};
          ov_d  = cnt_q == 3'd5;
          od_d  = ov_d ? dl_q[4] : 8'h00;
          cnt_d = ov_d ? cnt_q : cnt_q + 3'd1;
        end
      end
      default: if (!io_in_valid) state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      crc_q   <= '1;
      len_q   <= '0;
      cnt_q   <= '0;
      dl_q    <= '0;
      er_q    <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= 8'h00;
      ol_q    <= 1'b0;
      oe_q    <= 1'b0;
      good_q  <= '0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      dl_q    <= dl_d;
      er_q    <= er_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      ol_q    <= ol_d;
      oe_q    <= oe_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
    end
  end
  assign io_out_valid   = ov_q;
  assign io_out_data    = od_q;
  assign io_out_last    = ol_q;
  assign io_out_error   = oe_q;
  assign io_good_frames = good_q;
  assign io_bad_frames  = bad_q;
endmodule

// File: tb/tb_ethernet_rx_frame.sv
// tb_ethernet_rx_frame: directed frames with a bench-side CRC-32 model and expected beat streams.
module tb_ethernet_rx_frame;
  logic clock = 1'b0, reset = 1'b1;
  logic [7:0] io_in_data = 8'h00;
  logic io_in_valid = 1'b0, io_in_error = 1'b0;
  logic io_out_valid, io_out_last, io_out_error;
  logic [7:0] io_out_data;
  logic [15:0] io_good_frames, io_bad_frames;
  int vectors = 0, miscompares = 0, cyc = 0, mark_cyc = -1, eg = 0, eb = 0;
  logic [7:0] tx[$];
  logic [9:0] beats[$], want[$];
  int bcyc[$];

  ethernet_rx_frame dut (
    .clock(clock), .reset(reset), .io_in_data(io_in_data), .io_in_valid(io_in_valid),
    .io_in_error(io_in_error), .io_out_valid(io_out_valid), .io_out_data(io_out_data),
    .io_out_last(io_out_last), .io_out_error(io_out_error),
    .io_good_frames(io_good_frames), .io_bad_frames(io_bad_frames)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (io_out_valid) begin
    beats.push_back({io_out_error & io_out_last, io_out_last, io_out_data});
    bcyc.push_back(cyc);
  end

  // Standard Ethernet FCS: reflected CRC-32, final inversion, sent LSB byte first.
  function automatic logic [31:0] fcs_of();
    logic [31:0] c = '1;
    foreach (tx[i]) for (int k = 0; k < 8; k++) c = (c[0] ^ tx[i][k]) ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    return ~c;
  endfunction

  task automatic make_frame(input int n, input bit with_fcs, input bit bad_fcs);
    logic [31:0] f;
    tx.delete();
    for (int i = 0; i < n; i++) tx.push_back(i[7:0]);
    if (with_fcs) begin
      f = fcs_of();
      tx.push_back(f[7:0]); tx.push_back(f[15:8]); tx.push_back(f[23:16]); tx.push_back(f[31:24]);
      if (bad_fcs) tx[tx.size()-1] = tx[tx.size()-1] ^ 8'h01;
    end
  endtask

  task automatic add_want(input int n, input bit err);
    for (int j = 0; j < n; j++) want.push_back({err && j == n-1, j == n-1, j[7:0]});
  endtask

  task automatic put(input logic [7:0] d, input logic v, input logic e);
    io_in_data = d; io_in_valid = v; io_in_error = e;
    @(posedge clock); #1;
  endtask

  task automatic send(input int err_idx, input int mark_idx, input int gap);
    repeat (7) put(8'h55, 1'b1, 1'b0);
    put(8'hD5, 1'b1, 1'b0);
    foreach (tx[i]) begin
      put(tx[i], 1'b1, i == err_idx);
      if (i == mark_idx) mark_cyc = cyc;
    end
    repeat (gap) put(8'h00, 1'b0, 1'b0);
  endtask

  task automatic check_stream(input string name);
    int bad_at = -1;
    vectors++;
    if (beats.size() !== want.size()) begin
      miscompares++;
      $display("FAIL %s beat count: got %0d expected %0d", name, beats.size(), want.size());
    end
    for (int i = 0; i < beats.size() && i < want.size(); i++)
      if (bad_at < 0 && beats[i] !== want[i]) bad_at = i;
    vectors++;
    if (bad_at >= 0) begin
      miscompares++;
      $display("FAIL %s beat %0d {err,last,data}: got %h expected %h", name, bad_at, beats[bad_at], want[bad_at]);
    end
    beats.delete(); want.delete(); bcyc.delete();
  endtask

  task automatic check_counters(input string name);
    vectors++;
    if (io_good_frames !== 16'(eg)) begin
      miscompares++;
      $display("FAIL %s good_frames: got %0d expected %0d", name, io_good_frames, eg);
    end
    vectors++;
    if (io_bad_frames !== 16'(eb)) begin
      miscompares++;
      $display("FAIL %s bad_frames: got %0d expected %0d", name, io_bad_frames, eb);
    end
  endtask

  task automatic test_reset();
    repeat (3) put(8'h00, 1'b0, 1'b0);
    vectors++;
    if ({io_out_valid, io_out_last, io_out_error, io_out_data} !== 11'h0) begin
      miscompares++;
      $display("FAIL reset outputs: got %b expected 0", {io_out_valid, io_out_last, io_out_error, io_out_data});
    end
    check_counters("reset");
    reset = 1'b0;
    put(8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_good();
    make_frame(60, 1, 0);
    send(-1, 5, 4);
    vectors++;
    if (bcyc.size() == 0 || bcyc[0] !== mark_cyc) begin
      miscompares++;
      $display("FAIL good first-beat latency: got cycle %0d expected %0d", bcyc.size() ? bcyc[0] : -1, mark_cyc);
    end
    add_want(60, 0); eg++;
    check_stream("good"); check_counters("good");
  endtask

  task automatic test_bad_fcs();
    make_frame(60, 1, 1);
    send(-1, -1, 4);
    add_want(60, 1); eb++;
    check_stream("bad_fcs"); check_counters("bad_fcs");
  endtask

  task automatic test_lengths();
    make_frame(59, 1, 0);
    send(-1, -1, 4);
    add_want(59, 1); eb++;
    check_stream("runt"); check_counters("runt");
    make_frame(1518, 1, 0);
    send(-1, -1, 4);
    add_want(1518, 0); eg++;
    check_stream("max_len"); check_counters("max_len");
  endtask

  task automatic test_oversize();
    make_frame(1600, 0, 0);
    send(-1, 1522, 4);
    vectors++;
    if (bcyc.size() == 0 || bcyc[bcyc.size()-1] !== mark_cyc) begin
      miscompares++;
      $display("FAIL oversize last-beat cycle: got %0d expected %0d", bcyc.size() ? bcyc[bcyc.size()-1] : -1, mark_cyc);
    end
    add_want(1518, 1); eb++;
    check_stream("oversize"); check_counters("oversize");
  endtask

  task automatic test_rx_er();
    make_frame(60, 1, 0);
    send(10, -1, 4);
    add_want(60, 1); eb++;
    check_stream("rx_er"); check_counters("rx_er");
  endtask

  task automatic test_preamble();
    for (int i = 0; i < 7; i++) put(8'h55, 1'b1, i == 2);
    put(8'hD5, 1'b1, 1'b0);
    repeat (10) put(8'h11, 1'b1, 1'b0);
    repeat (3) put(8'h00, 1'b0, 1'b0);
    eb++;
    check_stream("preamble_er"); check_counters("preamble_er");
    put(8'h55, 1'b1, 1'b0); put(8'h54, 1'b1, 1'b0); put(8'h55, 1'b1, 1'b0); put(8'hD5, 1'b1, 1'b0);
    repeat (10) put(8'h22, 1'b1, 1'b0);
    repeat (3) put(8'h00, 1'b0, 1'b0);
    vectors++;
    if (beats.size() !== 0) begin
      miscompares++;
      $display("FAIL bad_preamble beats: got %0d expected 0", beats.size());
    end
    beats.delete(); bcyc.delete();
    make_frame(60, 1, 0);
    send(-1, -1, 4);
    add_want(60, 0); eg++;
    check_stream("after_bad_preamble");
    vectors++;
    if (io_good_frames !== 16'(eg)) begin
      miscompares++;
      $display("FAIL after_bad_preamble good_frames: got %0d expected %0d", io_good_frames, eg);
    end
  endtask

  task automatic test_short();
    make_frame(3, 0, 0);
    send(-1, -1, 4);
    eb++;
    check_stream("short"); check_counters("short");
  endtask

  task automatic test_back_to_back();
    make_frame(60, 1, 0);
    send(-1, -1, 1);
    send(-1, -1, 4);
    add_want(60, 0); add_want(60, 0); eg += 2;
    check_stream("back_to_back"); check_counters("back_to_back");
  endtask

  task automatic test_mid_reset();
    make_frame(60, 1, 0);
    repeat (7) put(8'h55, 1'b1, 1'b0);
    put(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i <= 30; i++) put(tx[i], 1'b1, 1'b0);
    vectors++;
    if (io_out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset pre-reset valid: got %b expected 1", io_out_valid);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({io_out_valid, io_out_last, io_out_error, io_out_data} !== 11'h0) begin
      miscompares++;
      $display("FAIL mid_reset outputs: got %b expected 0", {io_out_valid, io_out_last, io_out_error, io_out_data});
    end
    eg = 0; eb = 0;
    check_counters("mid_reset");
    put(tx[31], 1'b1, 1'b0); put(tx[32], 1'b1, 1'b0);
    reset = 1'b0;
    for (int i = 33; i < 60; i++) put(tx[i], 1'b1, 1'b0);
    repeat (3) put(8'h00, 1'b0, 1'b0);
    beats.delete(); bcyc.delete();
    send(-1, -1, 4);
    add_want(60, 0); eg++;
    check_stream("after_reset"); check_counters("after_reset");
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad_fcs();
    test_lengths();
    test_oversize();
    test_rx_er();
    test_preamble();
    test_short();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
